// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module      : window_gen_3x3
// Description : Streaming 3x3 window generator for conv_unit. Accepts one
//               24-bit RGB pixel per handshake in raster order, keeps two
//               line buffers plus a shift window, and emits a 216-bit window
//               for every interior position through a single output register.
//               Optional macro WIN_GEN_EOF_EN adds the win_last output.
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen_3x3 #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         pix_valid,
   input  logic [23:0]  pix_in,
   output logic         pix_ready,
   output logic         win_valid,
   output logic [215:0] win_data,
   input  logic         win_ready
`ifdef WIN_GEN_EOF_EN
   ,
   output logic         win_last
`endif
);

   localparam int c_COL_W = $clog2(IMG_W);
   localparam int c_ROW_W = $clog2(IMG_H);
   localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(IMG_W - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(IMG_H - 1);
   localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(2);
   localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(2);

   logic [c_COL_W-1:0] r_col;
   logic [c_ROW_W-1:0] r_row;
   logic [23:0]        r_lb_top [IMG_W];
   logic [23:0]        r_lb_mid [IMG_W];
   // Two most recent columns of the window, each {top, mid, bottom}; the
   // third (newest) column is formed from the line buffers and pix_in.
   logic [71:0]        r_win_c0;
   logic [71:0]        r_win_c1;
   logic               r_win_valid;
   logic [215:0]       r_win_data;

   logic               w_accept;
   logic               w_emit;
   logic [71:0]        w_new_col;
   logic [71:0]        w_cols [3];
   logic [215:0]       w_win_packed;

   assign pix_ready = ~r_win_valid | win_ready;
   assign w_accept  = pix_valid & pix_ready;
   assign w_emit    = w_accept & (r_row >= c_ROW_FIRST) & (r_col >= c_COL_FIRST);
   assign w_new_col = {r_lb_top[r_col], r_lb_mid[r_col], pix_in};

   // Pack the window row-major: pixel (i,j) at [215-24*(3i+j) -: 24].
   always_comb begin
      w_win_packed = '0;
      w_cols[0]    = r_win_c0;
      w_cols[1]    = r_win_c1;
      w_cols[2]    = w_new_col;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_win_packed[215-24*(3*i+j) -: 24] = w_cols[j][71-24*i -: 24];
         end
      end
   end

   // Raster position counters, advancing only on an accepted pixel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Line buffers and window columns; contents are refilled before use, so
   // they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb_top[r_col] <= r_lb_mid[r_col];
         r_lb_mid[r_col] <= pix_in;
         r_win_c0        <= r_win_c1;
         r_win_c1        <= w_new_col;
      end
   end

   // Output register: loads on an emitting pixel, clears on consumption.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_win_valid <= 1'b0;
         r_win_data  <= '0;
      end else if (w_emit) begin
         r_win_valid <= 1'b1;
         r_win_data  <= w_win_packed;
      end else if (win_ready) begin
         r_win_valid <= 1'b0;
      end
   end

   assign win_valid = r_win_valid;
   assign win_data  = r_win_data;

`ifdef WIN_GEN_EOF_EN
   logic r_win_last;
   logic w_is_last;

   assign w_is_last = (r_row == c_ROW_LAST) & (r_col == c_COL_LAST);

   // End-of-frame flag held alongside the window data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_win_last <= 1'b0;
      end else if (w_emit) begin
         r_win_last <= w_is_last;
      end
   end

   assign win_last = r_win_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_gen_3x3
// Description : Scoreboard testbench for window_gen_3x3 with IMG_W=IMG_H=4.
//               Expected windows are built from a bench-side image model;
//               a negedge monitor compares every consumed window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen_3x3;

   localparam int W = 4;
   localparam int H = 4;
`ifdef WIN_GEN_EOF_EN
   localparam bit EOF = 1'b1;
`else
   localparam bit EOF = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic         pix_valid;
   logic [23:0]  pix_in;
   logic         pix_ready;
   logic         win_valid;
   logic [215:0] win_data;
   logic         win_ready;
   logic         act_last;

   int           n_vec = 0;
   int           n_miss = 0;
   int           n_pop = 0;
   int           last_wait = 0;
   int           mr = 0;
   int           mc = 0;
   logic [7:0]   img [H][W];
   logic [216:0] sb_q [$];

   always #5 clk = ~clk;

   window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .pix_valid (pix_valid),
      .pix_in    (pix_in),
      .pix_ready (pix_ready),
      .win_valid (win_valid),
      .win_data  (win_data),
      .win_ready (win_ready)
`ifdef WIN_GEN_EOF_EN
      ,
      .win_last  (act_last)
`endif
   );

`ifndef WIN_GEN_EOF_EN
   assign act_last = 1'b0;
`endif

   task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [215:0] exp_win(input int r, input int c);
      logic [215:0] w;
      logic [7:0]   p;
      w = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            p = img[r-2+i][c-2+j];
            w[215-24*(3*i+j) -: 24] = {p, p, p};
         end
      end
      return w;
   endfunction

   // Offer pixel {k,k,k}; entered and left at posedge+1.
   task automatic send(input logic [7:0] k);
      int           n;
      logic         emit;
      logic [215:0] ew;
      ew = '0;
      img[mr][mc] = k;
      pix_valid = 1'b1;
      pix_in    = {k, k, k};
      #1;
      n = 0;
      while (pix_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      last_wait = n;
      if (n >= 50) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout: got no pix_ready expected pix_ready=1 within 50 cycles");
         pix_valid = 1'b0;
         return;
      end
      emit = (mr >= 2) && (mc >= 2);
      if (emit) begin
         ew = exp_win(mr, mc);
         sb_q.push_back({EOF && (mr == H-1) && (mc == W-1), ew});
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      if (emit) begin
         chk("latency_valid", win_valid, 216'd1);
         chk("latency_data", win_data, ew);
      end
      if (mc == W-1) begin
         mc = 0;
         mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
   endtask

   task automatic drain(input string name, input int exp_pops);
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_queue_empty"}, 216'(sb_q.size()), 216'd0);
      chk({name, "_window_count"}, 216'(n_pop), 216'(exp_pops));
   endtask

   // Monitor: compare every window consumed by the downstream stage.
   always @(negedge clk) begin
      logic [216:0] e;
      if (resetn === 1'b1 && win_valid === 1'b1 && win_ready === 1'b1) begin
         n_pop++;
         n_vec++;
         if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL spurious_window: got %h expected no window", win_data);
         end else begin
            e = sb_q.pop_front();
            if ({act_last, win_data} !== e) begin
               n_miss++;
               $display("FAIL window: got last=%b data=%h expected last=%b data=%h",
                        act_last, win_data, e[216], e[215:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      pix_valid = 1'b0;
      pix_in    = '0;
      win_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_win_valid", win_valid, 216'd0);
      chk("reset_win_data", win_data, 216'd0);
      chk("reset_pix_ready", pix_ready, 216'd1);
      chk("reset_win_last", act_last, 216'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // First window, then backpressure, then finish the frame.
      n_pop = 0;
      for (int k = 0; k < 11; k++) send(8'(k));
      chk("first_win_top", win_data[215:192], 216'h000000);
      chk("first_win_bot", win_data[23:0], 216'h0A0A0A);
      win_ready = 1'b0;
      pix_valid = 1'b1;
      pix_in    = 24'h0B0B0B;
      repeat (5) begin
         #1;
         chk("bp_pix_ready", pix_ready, 216'd0);
         chk("bp_win_data", win_data, exp_win(2, 2));
         @(posedge clk);
         #1;
      end
      win_ready = 1'b1;
      send(8'd11);
      chk("bp_release_same_edge", 216'(last_wait), 216'd0);
      for (int k = 12; k < 16; k++) send(8'(k));
      drain("frame1", 4);

      // Two frames back to back.
      n_pop = 0;
      for (int k = 0; k < 32; k++) begin
         send(8'(k));
         if (k == 14) chk("eof_not_last", act_last, 216'd0);
         if (k == 15) begin
            chk("full_frame_last_window", win_data,
                216'h050505_060606_070707_090909_0A0A0A_0B0B0B_0D0D0D_0E0E0E_0F0F0F);
            chk("eof_last", act_last, 216'(EOF));
         end
         if (k == 26) begin
            chk("frame2_first_window", win_data,
                216'h101010_111111_121212_141414_151515_161616_181818_191919_1A1A1A);
         end
      end
      drain("frames", 8);

      // Reset with a window pending.
      for (int k = 0; k < 12; k++) send(8'h40 + 8'(k));
      win_ready = 1'b0;
      #1;
      chk("pending_before_reset", win_valid, 216'd1);
      resetn = 1'b0;
      #1;
      chk("midreset_win_valid", win_valid, 216'd0);
      chk("midreset_win_data", win_data, 216'd0);
      chk("midreset_pix_ready", pix_ready, 216'd1);
      sb_q.delete();
      mr = 0;
      mc = 0;
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      win_ready = 1'b1;
      n_pop     = 0;
      for (int k = 0; k < 10; k++) begin
         send(8'h80 + 8'(k));
         chk("post_reset_no_window", win_valid, 216'd0);
      end
      send(8'h8A);
      chk("post_reset_win_top", win_data[215:192], 216'h808080);
      chk("post_reset_win_bot", win_data[23:0], 216'h8A8A8A);
      drain("post_reset", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
